mem_copy: RTL and testbench

Memory-bus initiator that copies or fills a block of 32-bit words over the single-port synchronous memory interface also driven by `Pipeline`. It sits beside the core, or replaces it in stand-alone benches, as a second requester on the `Memory` port. A one-cycle `start` strobe launches it, and it reports completion with a `done` pulse. Bus arbitration with the core is outside this block.

---
 rtl/mem_copy_pkg.sv | 15 +
 rtl/mem_copy_if.sv | 26 ++
 rtl/mem_copy.sv | 109 ++++++++++
 tb/tb_mem_copy.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the mem_copy bus initiator.
package mem_copy_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/mem_copy_if.sv
// Single-port synchronous memory bus; read data returns one cycle after the address.
interface mem_copy_if;

    logic        mem_wren;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;

    modport master (
        output mem_wren,
        output mem_wmask,
        output mem_wdata,
        output mem_addr,
        input  mem_rdata
    );

    modport slave (
        input  mem_wren,
        input  mem_wmask,
        input  mem_wdata,
        input  mem_addr,
        output mem_rdata
    );

endinterface

// File: rtl/mem_copy.sv
// Word copy / fill engine: one start strobe runs a job over the memory bus, done pulses at the end.
module mem_copy
    import mem_copy_pkg::*;
#(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [31:0]          src,
    input  logic [31:0]          dst,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic [31:0]          pattern,
    output logic                 busy,
    output logic                 done,
    mem_copy_if.master           mem
);

    localparam logic [31:0] STEP       = 32'(WORD_BYTES);
    localparam logic [31:0] ALIGN_MASK = ~(STEP - 32'd1);

    state_t               state_q, state_d;
    logic                 mode_q, mode_d;
    logic [31:0]          src_q, src_d;
    logic [31:0]          dst_q, dst_d;
    logic [31:0]          pat_q, pat_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic                 done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_COPY;
            src_q   <= '0;
            dst_q   <= '0;
            pat_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            pat_q   <= pat_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        src_d   = src_q;
        dst_d   = dst_q;
        pat_d   = pat_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d = mode;
                    src_d  = src & ALIGN_MASK;
                    dst_d  = dst & ALIGN_MASK;
                    pat_d  = pattern;
                    rem_d  = len;
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = (mode == MODE_FILL) ? WRITE : READ;
                    end
                end
            end
            READ: state_d = WRITE;
            WRITE: begin
                // Pointers wrap modulo 2^32 by construction.
                src_d = src_q + STEP;
                dst_d = dst_q + STEP;
                rem_d = rem_q - LEN_WIDTH'(1);
                if (rem_q == LEN_WIDTH'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = (mode_q == MODE_COPY) ? READ : WRITE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Everything but the copy write data comes straight from registered state.
    always_comb begin
        busy          = (state_q != IDLE);
        done          = done_q;
        mem.mem_wren  = (state_q == WRITE);
        mem.mem_wmask = (state_q == WRITE) ? 4'hF : 4'h0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        case (state_q)
            READ: mem.mem_addr = src_q;
            WRITE: begin
                mem.mem_addr  = dst_q;
                mem.mem_wdata = (mode_q == MODE_COPY) ? mem.mem_rdata : pat_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_copy.sv
// Self-checking bench for mem_copy: cycle-exact bus trace and memory image against a word-level model.
module tb_mem_copy;
    import mem_copy_pkg::*;

    typedef struct {
        logic        busy;
        logic        done;
        logic        wren;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start, mode;
    logic [31:0] src, dst, pattern;
    logic [15:0] len;
    logic        busy, done;

    logic        clr, pre_we;
    logic [31:0] pre_addr, pre_data;
    logic [31:0] ram     [0:1023];
    logic [31:0] ref_mem [0:1023];

    int n_chk = 0;
    int n_bad = 0;

    mem_copy_if bus();

    mem_copy #(.LEN_WIDTH(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .src    (src),
        .dst    (dst),
        .len    (len),
        .pattern(pattern),
        .busy   (busy),
        .done   (done),
        .mem    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] idx(input logic [31:0] a);
        return 10'((a >> 2) % 32'd1024);
    endfunction

    // Synchronous memory: read data registered, writes land at the edge.
    always @(posedge clk) begin
        bus.mem_rdata <= ram[idx(bus.mem_addr)];
        if (clr) begin
            for (int i = 0; i < 1024; i++) ram[i] <= '0;
        end else if (pre_we) begin
            ram[idx(pre_addr)] <= pre_data;
        end else if (bus.mem_wren && bus.mem_wmask == 4'hF) begin
            ram[idx(bus.mem_addr)] <= bus.mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic b, input logic d, input logic w,
                                input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        e.busy = b; e.done = d; e.wren = w; e.addr = a; e.wdata = wd;
        return e;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        pre_we = 1'b1; pre_addr = a; pre_data = v;
        ref_mem[idx(a)] = v;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        int diff = 0;
        for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) diff++;
        chk(tag, diff, 0);
    endtask

    task automatic scramble_inputs();
        mode    = 1'($urandom);
        src     = $urandom;
        dst     = $urandom;
        len     = 16'($urandom);
        pattern = $urandom;
    endtask

    // Called at a negedge; the next posedge samples start. poke_cyc re-asserts start
    // mid-job, abort_cyc raises rst during that cycle and checks the reset state after.
    task automatic run_job(input string name, input logic m, input logic [31:0] s,
                           input logic [31:0] d, input logic [15:0] n, input logic [31:0] p,
                           input int poke_cyc, input int abort_cyc);
        exp_t        q[$];
        exp_t        e;
        logic [31:0] sh [0:1023];
        logic [31:0] sp, dp, v;
        sh = ref_mem;
        sp = s & ~32'h3;
        dp = d & ~32'h3;
        for (int i = 0; i < int'(n); i++) begin
            if (m == MODE_COPY) begin
                v = sh[idx(sp)];
                q.push_back(mk(1'b1, 1'b0, 1'b0, sp, 32'h0));
            end else begin
                v = p;
            end
            q.push_back(mk(1'b1, 1'b0, 1'b1, dp, v));
            sh[idx(dp)] = v;
            sp += 32'd4;
            dp += 32'd4;
        end
        q.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 32'h0));

        mode = m; src = s; dst = d; len = n; pattern = p; start = 1'b1;
        for (int c = 1; c <= q.size(); c++) begin
            @(negedge clk);
            scramble_inputs();
            start = (c == poke_cyc);
            e = q[c-1];
            chk($sformatf("%s ctl c%0d", name, c),
                {25'b0, busy, done, bus.mem_wren, bus.mem_wmask},
                {25'b0, e.busy, e.done, e.wren, (e.wren ? 4'hF : 4'h0)});
            if (e.busy) chk($sformatf("%s addr c%0d", name, c), bus.mem_addr, e.addr);
            if (e.wren) begin
                chk($sformatf("%s wdata c%0d", name, c), bus.mem_wdata, e.wdata);
                ref_mem[idx(e.addr)] = e.wdata;
            end
            if (c == abort_cyc) begin
                rst = 1'b1;
                start = 1'b0;
                @(negedge clk);
                chk($sformatf("%s rst ctl", name), {25'b0, busy, done, bus.mem_wren, bus.mem_wmask}, 32'h0);
                chk($sformatf("%s rst addr", name), bus.mem_addr, 32'h0);
                chk($sformatf("%s rst wdata", name), bus.mem_wdata, 32'h0);
                rst = 1'b0;
                check_mem({name, " mem"});
                return;
            end
        end
        start = 1'b0;
        check_mem({name, " mem"});
    endtask

    initial begin
        rst = 1'b1; clr = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0;
        len = '0; pattern = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 4; i++) preload(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));

        chk("reset ctl", {25'b0, busy, done, bus.mem_wren, bus.mem_wmask}, 32'h0);
        chk("reset addr", bus.mem_addr, 32'h0);
        chk("reset wdata", bus.mem_wdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        run_job("copy4", MODE_COPY, 32'h100, 32'h200, 16'd4, 32'h0, 0, 0);
        chk("copy4 dst0", ram[idx(32'h200)], 32'hA0);
        chk("copy4 dst3", ram[idx(32'h20C)], 32'hA3);
        chk("copy4 src3", ram[idx(32'h10C)], 32'hA3);
        @(negedge clk);
        run_job("fill3", MODE_FILL, 32'h0, 32'h303, 16'd3, 32'hDEADBEEF, 0, 0);
        @(negedge clk);
        run_job("zero", MODE_COPY, 32'h100, 32'h700, 16'd0, 32'h0, 0, 0);
        @(negedge clk);
        run_job("poke", MODE_COPY, 32'h100, 32'h400, 16'd2, 32'h0, 2, 0);
        run_job("b2b", MODE_FILL, 32'h0, 32'h500, 16'd2, 32'h12345678, 0, 0);
        @(negedge clk);
        run_job("abort", MODE_COPY, 32'h100, 32'h600, 16'd4, 32'h0, 0, 4);
        chk("abort w2", ram[idx(32'h608)], 32'h0);
        @(negedge clk);
        run_job("wrap", MODE_FILL, 32'h0, 32'hFFFFFFF8, 16'd3, 32'hCAFEF00D, 0, 0);
        @(negedge clk);
        run_job("overlap", MODE_COPY, 32'h100, 32'h104, 16'd3, 32'h0, 0, 0);
        chk("overlap rep", ram[idx(32'h10C)], 32'hA0);

        for (int k = 0; k < 25; k++) begin
            logic [31:0] rs, rd;
            rs = 32'($urandom_range(0, 4095));
            rd = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            run_job($sformatf("rnd%0d", k), 1'($urandom), rs, rd,
                    16'($urandom_range(0, 10)), $urandom, 0, 0);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
